// File: rtl/periph_stall_ctrl.sv
// periph_stall_ctrl
// This block runs peripheral loads and stores that sit in the MEM stage.
// While the bus request/ready handshake is in progress it holds the front of
// the pipeline and puts a bubble into MEM/WB. It then releases the pipeline
// with the captured read data. A bus error or a timeout raises a one-cycle
// fault pulse and records the faulting address.
module periph_stall_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        isPeripheralM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  StrobeM,
  output logic        PReq,
  output logic        PWrite,
  output logic [31:0] PAddr,
  output logic [31:0] PWData,
  output logic [2:0]  PStrobe,
  input  logic        PReady,
  input  logic [31:0] PRData,
  input  logic        PErr,
  output logic        PipeEN,
  output logic        FlushW,
  output logic [31:0] ReadDataP,
  output logic        BusFault,
  output logic [31:0] FaultAddr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // The timeout fires in the ACCESS cycle whose counter holds this value,
  // so PReq stays high for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc;
  logic             timeout_hit;

  assign acc         = isPeripheralM & (MemReadM | MemWriteM);
  assign timeout_hit = (wait_cnt == CNT_LAST);

  // State register; reset abandons any request that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and pipeline-enable decode. PipeEN does not depend on PReady,
  // so the release always comes one cycle after the handshake completes.
  always_comb begin
    state_d = state_q;
    PipeEN  = 1'b1;
    case (state_q)
      IDLE: begin
        PipeEN = ~acc;
        if (acc) state_d = ACCESS;
      end
      ACCESS: begin
        PipeEN = 1'b0;
        if (PReady || timeout_hit) state_d = RESP;
      end
      RESP: begin
        PipeEN  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        PipeEN  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign FlushW = ~PipeEN;

  // Bus-side registers: latch the access when it is detected, capture the
  // response or a timeout, and produce the fault pulse seen during RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PReq      <= 1'b0;
      PWrite    <= 1'b0;
      PAddr     <= '0;
      PWData    <= '0;
      PStrobe   <= '0;
      wait_cnt  <= '0;
      ReadDataP <= '0;
      BusFault  <= 1'b0;
      FaultAddr <= '0;
    end else begin
      BusFault <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            PAddr    <= ALUResultM;
            PWData   <= WriteDataM;
            PStrobe  <= StrobeM;
            PWrite   <= MemWriteM;
            PReq     <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (PReady) begin
            if (!PWrite) ReadDataP <= PRData;
            if (PErr) begin
              BusFault  <= 1'b1;
              FaultAddr <= PAddr;
            end
            PReq <= 1'b0;
          end else if (timeout_hit) begin
            if (!PWrite) ReadDataP <= '0;
            BusFault  <= 1'b1;
            FaultAddr <= PAddr;
            PReq      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_stall_ctrl.sv
// tb_periph_stall_ctrl
// Directed cycle-by-cycle vectors for the peripheral stall sequencer, built
// with TIMEOUT = 4, followed by a hand-written reset-during-access sequence.
module tb_periph_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        MemReadM;
  logic        MemWriteM;
  logic        isPeripheralM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  StrobeM;
  logic        PReq;
  logic        PWrite;
  logic [31:0] PAddr;
  logic [31:0] PWData;
  logic [2:0]  PStrobe;
  logic        PReady;
  logic [31:0] PRData;
  logic        PErr;
  logic        PipeEN;
  logic        FlushW;
  logic [31:0] ReadDataP;
  logic        BusFault;
  logic [31:0] FaultAddr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A10 = 32'h4000_0010;
  localparam logic [31:0] A20 = 32'h4000_0020;
  localparam logic [31:0] A30 = 32'h4000_0030;
  localparam logic [31:0] A40 = 32'h4000_0040;
  localparam logic [31:0] A50 = 32'h4000_0050;
  localparam logic [31:0] A60 = 32'h4000_0060;
  localparam logic [31:0] A70 = 32'h4000_0070;
  localparam logic [31:0] A80 = 32'h4000_0080;
  localparam logic [31:0] WD  = 32'h1234_5678;
  localparam logic [31:0] DB  = 32'hDEAD_BEEF;
  localparam logic [31:0] CF  = 32'hCAFE_F00D;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        per;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    logic [31:0] rdat;
    logic        err;
    logic        ePReq;
    logic        ePWrite;
    logic [31:0] ePAddr;
    logic [31:0] ePWData;
    logic        ePipe;
    logic        eBf;
    logic [31:0] eRdp;
    logic [31:0] eFa;
  } vec_t;

  vec_t vecs[$];

  periph_stall_ctrl #(.CNT_W(8), .TIMEOUT(4)) dut (
    .clk(clk),
    .rst(rst),
    .MemReadM(MemReadM),
    .MemWriteM(MemWriteM),
    .isPeripheralM(isPeripheralM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .StrobeM(StrobeM),
    .PReq(PReq),
    .PWrite(PWrite),
    .PAddr(PAddr),
    .PWData(PWData),
    .PStrobe(PStrobe),
    .PReady(PReady),
    .PRData(PRData),
    .PErr(PErr),
    .PipeEN(PipeEN),
    .FlushW(FlushW),
    .ReadDataP(ReadDataP),
    .BusFault(BusFault),
    .FaultAddr(FaultAddr)
  );

  // Free-running pipeline clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addRow(input logic rd, input logic wr, input logic per,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rdy, input logic [31:0] rdat, input logic err,
                        input logic ePReq, input logic ePWrite,
                        input logic [31:0] ePAddr, input logic [31:0] ePWData,
                        input logic ePipe, input logic eBf,
                        input logic [31:0] eRdp, input logic [31:0] eFa);
    vec_t v;
    v.rd = rd; v.wr = wr; v.per = per; v.addr = addr; v.wdata = wdata;
    v.rdy = rdy; v.rdat = rdat; v.err = err;
    v.ePReq = ePReq; v.ePWrite = ePWrite; v.ePAddr = ePAddr; v.ePWData = ePWData;
    v.ePipe = ePipe; v.eBf = eBf; v.eRdp = eRdp; v.eFa = eFa;
    vecs.push_back(v);
  endtask

  task automatic checkBit(input string name, input int row, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s row %0d got %b want %b", name, row, got, want);
    end
  endtask

  task automatic checkVal(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s row %0d got %h want %h", name, row, got, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    MemReadM      = v.rd;
    MemWriteM     = v.wr;
    isPeripheralM = v.per;
    ALUResultM    = v.addr;
    WriteDataM    = v.wdata;
    StrobeM       = 3'b010;
    PReady        = v.rdy;
    PRData        = v.rdat;
    PErr          = v.err;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    checkBit("PReq", row, PReq, v.ePReq);
    checkBit("PWrite", row, PWrite, v.ePWrite);
    checkVal("PAddr", row, PAddr, v.ePAddr);
    checkVal("PWData", row, PWData, v.ePWData);
    checkBit("PipeEN", row, PipeEN, v.ePipe);
    checkBit("FlushW", row, FlushW, ~v.ePipe);
    checkBit("BusFault", row, BusFault, v.eBf);
    checkVal("ReadDataP", row, ReadDataP, v.eRdp);
    checkVal("FaultAddr", row, FaultAddr, v.eFa);
  endtask

  task automatic driveIdle();
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    isPeripheralM = 1'b0;
    ALUResultM    = '0;
    WriteDataM    = '0;
    StrobeM       = '0;
    PReady        = 1'b0;
    PRData        = '0;
    PErr          = 1'b0;
  endtask

  initial begin
    // Non-peripheral accesses, with a spurious PReady/PErr while IDLE
    addRow(1,0,0,32'h1000,0,      1,32'hFFFF_FFFF,1, 0,0,0,  0, 1,0,0, 0);
    addRow(1,0,0,32'h1004,0,      0,0,0,             0,0,0,  0, 1,0,0, 0);
    addRow(0,1,0,32'h1008,32'hAAAA,0,0,0,            0,0,0,  0, 1,0,0, 0);
    // Peripheral load, PReady in cycle 1
    addRow(1,0,1,A10,0,           0,0,0,             0,0,0,  0, 0,0,0, 0);
    addRow(1,0,1,A10,0,           1,DB,0,            1,0,A10,0, 0,0,0, 0);
    addRow(1,0,1,A10,0,           0,0,0,             0,0,A10,0, 1,0,DB,0);
    addRow(0,0,0,0,0,             0,0,0,             0,0,A10,0, 1,0,DB,0);
    // Peripheral store, PReady in cycle 4 (also the timeout cycle); PReady/PErr in RESP ignored
    addRow(0,1,1,A20,WD,          0,0,0,             0,0,A10,0, 0,0,DB,0);
    addRow(0,1,1,A20,WD,          0,0,0,             1,1,A20,WD,0,0,DB,0);
    addRow(0,1,1,A20,WD,          0,0,0,             1,1,A20,WD,0,0,DB,0);
    addRow(0,1,1,A20,WD,          0,0,0,             1,1,A20,WD,0,0,DB,0);
    addRow(0,1,1,A20,WD,          1,32'h5555_5555,0, 1,1,A20,WD,0,0,DB,0);
    addRow(0,1,1,A20,WD,          1,32'h9999_9999,1, 0,1,A20,WD,1,0,DB,0);
    addRow(0,0,0,0,0,             0,0,0,             0,1,A20,WD,1,0,DB,0);
    // Load with error response in cycle 2
    addRow(1,0,1,A30,0,           0,0,0,             0,1,A20,WD,0,0,DB,0);
    addRow(1,0,1,A30,0,           0,0,0,             1,0,A30,0, 0,0,DB,0);
    addRow(1,0,1,A30,0,           1,CF,1,            1,0,A30,0, 0,0,DB,0);
    addRow(1,0,1,A30,0,           0,0,0,             0,0,A30,0, 1,1,CF,A30);
    addRow(0,0,0,0,0,             0,0,0,             0,0,A30,0, 1,0,CF,A30);
    // Load that times out
    addRow(1,0,1,A40,0,           0,0,0,             0,0,A30,0, 0,0,CF,A30);
    addRow(1,0,1,A40,0,           0,0,0,             1,0,A40,0, 0,0,CF,A30);
    addRow(1,0,1,A40,0,           0,0,0,             1,0,A40,0, 0,0,CF,A30);
    addRow(1,0,1,A40,0,           0,0,0,             1,0,A40,0, 0,0,CF,A30);
    addRow(1,0,1,A40,0,           0,0,0,             1,0,A40,0, 0,0,CF,A30);
    addRow(1,0,1,A40,0,           0,0,0,             0,0,A40,0, 1,1,0, A40);
    addRow(0,0,0,0,0,             0,0,0,             0,0,A40,0, 1,0,0, A40);
    // Back-to-back peripheral loads
    addRow(1,0,1,A50,0,           0,0,0,             0,0,A40,0, 0,0,0, A40);
    addRow(1,0,1,A50,0,           1,32'h1111_1111,0, 1,0,A50,0, 0,0,0, A40);
    addRow(1,0,1,A50,0,           0,0,0,             0,0,A50,0, 1,0,32'h1111_1111,A40);
    addRow(1,0,1,A60,0,           0,0,0,             0,0,A50,0, 0,0,32'h1111_1111,A40);
    addRow(1,0,1,A60,0,           1,32'h2222_2222,0, 1,0,A60,0, 0,0,32'h1111_1111,A40);
    addRow(1,0,1,A60,0,           0,0,0,             0,0,A60,0, 1,0,32'h2222_2222,A40);
    addRow(0,0,0,0,0,             0,0,0,             0,0,A60,0, 1,0,32'h2222_2222,A40);

    // Reset state
    rst = 1'b0;
    driveIdle();
    #1;
    checkBit("rst_PReq", -1, PReq, 1'b0);
    checkBit("rst_PWrite", -1, PWrite, 1'b0);
    checkVal("rst_PAddr", -1, PAddr, 32'h0);
    checkVal("rst_PStrobe", -1, {29'b0, PStrobe}, 32'h0);
    checkBit("rst_PipeEN", -1, PipeEN, 1'b1);
    checkBit("rst_FlushW", -1, FlushW, 1'b0);
    checkBit("rst_BusFault", -1, BusFault, 1'b0);
    checkVal("rst_ReadDataP", -1, ReadDataP, 32'h0);
    checkVal("rst_FaultAddr", -1, FaultAddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i, vecs[i]);
      @(posedge clk); #1;
    end

    // Reset pulsed while a load is waiting in ACCESS
    MemReadM = 1'b1; isPeripheralM = 1'b1; ALUResultM = A70; StrobeM = 3'b101;
    @(negedge clk);
    checkBit("mid_idle_PipeEN", 0, PipeEN, 1'b0);
    @(posedge clk); #1;
    checkBit("mid_access_PReq", 1, PReq, 1'b1);
    checkVal("mid_access_PStrobe", 1, {29'b0, PStrobe}, 32'h5);
    checkVal("mid_access_PAddr", 1, PAddr, A70);
    #2;
    rst = 1'b0;
    #1;
    checkBit("mid_rst_PReq", 2, PReq, 1'b0);
    checkVal("mid_rst_PAddr", 2, PAddr, 32'h0);
    checkVal("mid_rst_ReadDataP", 2, ReadDataP, 32'h0);
    checkVal("mid_rst_FaultAddr", 2, FaultAddr, 32'h0);
    driveIdle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkBit("post_rst_PReq", 3, PReq, 1'b0);
    checkBit("post_rst_PipeEN", 3, PipeEN, 1'b1);
    @(posedge clk); #1;
    // A fresh access is detected immediately, showing the state is IDLE
    MemReadM = 1'b1; isPeripheralM = 1'b1; ALUResultM = A80; StrobeM = 3'b000;
    @(negedge clk);
    checkBit("post_rst_acc_PipeEN", 4, PipeEN, 1'b0);
    checkBit("post_rst_acc_PReq", 4, PReq, 1'b0);
    @(posedge clk); #1;
    PReady = 1'b1; PRData = 32'h7777_7777;
    @(negedge clk);
    checkBit("post_rst_req_PReq", 5, PReq, 1'b1);
    checkVal("post_rst_req_PAddr", 5, PAddr, A80);
    @(posedge clk); #1;
    PReady = 1'b0;
    @(negedge clk);
    checkBit("post_rst_resp_PipeEN", 6, PipeEN, 1'b1);
    checkVal("post_rst_resp_ReadDataP", 6, ReadDataP, 32'h7777_7777);
    @(posedge clk); #1;
    driveIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/periph_stall_ctrl.md
# periph_stall_ctrl

Sequencer for peripheral loads and stores issued from the MEM stage of the RV32I pipeline. It detects a peripheral access held in the EX/MEM register and freezes the front of the pipeline by driving the stage-register enables low. It then runs a request/ready transaction on the peripheral bus, injects a bubble into MEM/WB while stalled, and releases the pipeline with the read data captured. Bus errors and timeouts are flagged.

## Interface
Parameters:
- CNT_W, 8, width of the wait-cycle counter
- TIMEOUT, 255, number of ACCESS cycles without PReady before abort; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W−1

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- isPeripheralM  in  1  MEM-stage address targets the peripheral bus
- ALUResultM  in  32  access address
- WriteDataM  in  32  store data
- StrobeM  in  3  access size/sign code; passed through unchanged
- PReq  out  1  bus request, registered
- PWrite  out  1  1 = write, registered
- PAddr  out  32  registered address
- PWData  out  32  registered write data
- PStrobe  out  3  registered StrobeM
- PReady  in  1  transaction complete; sampled only in ACCESS
- PRData  in  32  read data, valid with PReady
- PErr  in  1  error response, valid with PReady
- PipeEN  out  1  enable for PC, IF/ID, ID/EX and EX/MEM registers; combinational
- FlushW  out  1  flush for MEM/WB register; combinational, equals ~PipeEN
- ReadDataP  out  32  captured read data
- BusFault  out  1  one-cycle pulse on error or timeout
- FaultAddr  out  32  address of the most recent faulting access

## Operation
- Access condition: Acc = isPeripheralM & (MemReadM | MemWriteM).
- States: IDLE, ACCESS, RESP. Encoding is free.
- IDLE
  - PipeEN = ~Acc.
  - If Acc: latch PAddr ← ALUResultM, PWData ← WriteDataM, PStrobe ← StrobeM, PWrite ← MemWriteM. Set PReq ← 1, clear the counter, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS
  - PipeEN = 0. PReq and all P* outputs stay stable.
  - If PReady: ReadDataP ← PRData when ~PWrite. Writes leave ReadDataP unchanged. If PErr, record the fault: BusFault pulses in RESP and FaultAddr ← PAddr. PReq ← 0, go to RESP.
  - Else if counter == TIMEOUT−1: timeout. ReadDataP ← 0 on a read, record the fault, PReq ← 0, go to RESP.
  - Else increment the counter.
- RESP
  - PipeEN = 1, so the access instruction advances to WB this cycle with ReadDataP valid.
  - BusFault = 1 only if a fault was recorded.
  - Always go to IDLE. The RESP → IDLE transition ignores Acc.
- Back-to-back peripheral accesses: the next access enters M after RESP and is detected in the following IDLE cycle.
- PReady or PErr outside ACCESS is ignored.
- PReady takes priority over timeout when both occur in the same cycle.

## Timing
- Reset values (asynchronous): state IDLE, PReq 0, PWrite 0, PAddr 0, PWData 0, PStrobe 0, counter 0, ReadDataP 0, BusFault 0, FaultAddr 0. PipeEN then follows ~Acc and FlushW follows Acc.
- Cycle flow, with Acc first seen in M at cycle 0:
  - cycle 0 (IDLE): PipeEN = 0.
  - cycle 1: PReq = 1.
  - cycle k: first cycle with PReady = 1 (k ≥ 1).
  - cycle k+1: RESP, PipeEN = 1.
- Stall cycles = k+1. Minimum occupancy in M is 3 cycles.
- Timeout with no PReady: PReq is high for cycles 1..TIMEOUT, RESP at cycle TIMEOUT+1, BusFault is high in that same cycle.
- Reset asserted mid-transaction: PReq drops immediately and the state returns to IDLE. The peripheral must tolerate an abandoned request.
- No combinational path from PReady to PipeEN. The release is always one cycle after PReady.

## Test plan
- Non-peripheral load (isPeripheralM = 0, MemReadM = 1) → PipeEN = 1 and PReq = 0 every cycle.
- Peripheral load, ALUResultM = 0x4000_0010, PReady at cycle 1 with PRData = 0xDEAD_BEEF → PipeEN low cycles 0–1, high cycle 2, ReadDataP = 0xDEADBEEF in cycle 2, FlushW high cycles 0–1.
- Peripheral store, WriteDataM = 0x1234_5678, PReady at cycle 4 → PWrite = 1, PWData stable cycles 1–4, PipeEN high cycle 5, ReadDataP unchanged.
- Load with PReady and PErr at cycle 2 → BusFault pulse in cycle 3 only, FaultAddr = access address.
- TIMEOUT = 4, PReady never asserted → PReq high cycles 1–4, RESP at cycle 5 with BusFault = 1, ReadDataP = 0.
- Two consecutive peripheral loads → second PReq rises two cycles after the first RESP. Reset pulsed during ACCESS → PReq = 0 immediately, IDLE after release.
